// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with free-run and counted-burst stepping.
// Optional all-zero lock-up recovery is compiled in when LFSR_GEN_LOCKUP_EN is defined.
module lfsr_gen #(
    parameter int unsigned     W          = 16,
    parameter logic [W-1:0]    TAPS       = 16'h002D,
    parameter logic [W-1:0]    RESET_SEED = 16'hACE1,
    parameter int unsigned     CW         = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [W-1:0]  seed,
    input  logic          run,
    input  logic          burst_start,
    input  logic [CW-1:0] burst_len,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  lfsr_out,
    output logic          bit_out,
    output logic          lockup
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  lfsr_q, lfsr_d;
    logic          busy_q, done_q;
    logic          step_en;
    logic          fb;
    logic [W-1:0]  shifted;

    assign step_en = run | (state_q == S_BURST);
    assign fb      = ^(lfsr_q & TAPS);
    assign shifted = {fb, lfsr_q[W-1:1]};

    // Burst FSM next-state: load aborts any burst back to IDLE without a done pulse
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (load) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (burst_start) begin
                        if (burst_len == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_BURST;
                            count_d = burst_len;
                        end
                    end
                end
                S_BURST: begin
                    if (count_q == CW'(1)) begin
                        state_d = S_DONE;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CW'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

`ifdef LFSR_GEN_LOCKUP_EN
    logic lockup_d, lockup_q;

    // Next register value: load wins, then a step (recovering from all-zero), else hold
    always_comb begin
        lfsr_d   = lfsr_q;
        lockup_d = 1'b0;
        if (load) begin
            lfsr_d = seed;
        end else if (step_en) begin
            if (lfsr_q == '0) begin
                lfsr_d   = RESET_SEED;
                lockup_d = 1'b1;
            end else begin
                lfsr_d = shifted;
            end
        end
    end

    // Lock-up pulse register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lockup_q <= 1'b0;
        else        lockup_q <= lockup_d;
    end

    assign lockup = lockup_q;
`else
    // Next register value: load wins, then a plain step, else hold
    always_comb begin
        lfsr_d = lfsr_q;
        if (load)         lfsr_d = seed;
        else if (step_en) lfsr_d = shifted;
    end

    assign lockup = 1'b0;
`endif

    // State, counter, shift register and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            lfsr_q  <= RESET_SEED;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
            busy_q  <= (state_d == S_BURST);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign lfsr_out = lfsr_q;
    assign bit_out  = lfsr_q[0];

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: a reference model pushes expected outputs
// into a queue before each edge; they are popped and compared one ns after it.
module tb_lfsr_gen;

    localparam int unsigned    W    = 16;
    localparam int unsigned    CW   = 8;
    localparam logic [W-1:0]   TAPS = 16'h002D;
    localparam logic [W-1:0]   SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [W-1:0]  seed;
    logic          run;
    logic          burst_start;
    logic [CW-1:0] burst_len;
    logic          busy, done, bit_out, lockup;
    logic [W-1:0]  lfsr_out;

    lfsr_gen #(.W(W), .TAPS(TAPS), .RESET_SEED(SEED), .CW(CW)) dut (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run),
        .burst_start(burst_start), .burst_len(burst_len), .busy(busy),
        .done(done), .lfsr_out(lfsr_out), .bit_out(bit_out), .lockup(lockup)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] lfsr;
        logic         busy;
        logic         done;
        logic         lockup;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int busy_seen = 0;
    int done_seen = 0;

    // Reference model: 0 idle, 1 burst, 2 done
    logic [W-1:0] m_lfsr;
    int           m_state;
    int           m_left;
    logic         m_lock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lfsr  = SEED;
        m_state = 0;
        m_left  = 0;
        m_lock  = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [W-1:0] ref_step(input logic [W-1:0] v);
        logic f;
        f = 1'b0;
        for (int i = 0; i < int'(W); i++)
            if (TAPS[i]) f = f ^ v[i];
        return {f, v[W-1:1]};
    endfunction

    // Advance the model by one edge using the currently driven inputs, then check the DUT
    task automatic tick();
        exp_t e;
        logic stepping;
        stepping = run || (m_state == 1);
        m_lock   = 1'b0;
        if (load) begin
            m_lfsr = seed;
        end else if (stepping) begin
`ifdef LFSR_GEN_LOCKUP_EN
            if (m_lfsr == '0) begin
                m_lfsr = SEED;
                m_lock = 1'b1;
            end else begin
                m_lfsr = ref_step(m_lfsr);
            end
`else
            m_lfsr = ref_step(m_lfsr);
`endif
        end
        if (load) begin
            m_state = 0;
            m_left  = 0;
        end else if (m_state == 0) begin
            if (burst_start) begin
                if (burst_len == 0) m_state = 2;
                else begin
                    m_state = 1;
                    m_left  = int'(burst_len);
                end
            end
        end else if (m_state == 1) begin
            m_left--;
            if (m_left == 0) m_state = 2;
        end else begin
            m_state = 0;
        end
        e.lfsr   = m_lfsr;
        e.busy   = (m_state == 1);
        e.done   = (m_state == 2);
        e.lockup = m_lock;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("lfsr_out", 32'(lfsr_out), 32'(e.lfsr));
        check_val("bit_out", 32'(bit_out), 32'(e.lfsr[0]));
        check_val("busy", 32'(busy), 32'(e.busy));
        check_val("done", 32'(done), 32'(e.done));
        check_val("lockup", 32'(lockup), 32'(e.lockup));
        if (busy) busy_seen++;
        if (done) done_seen++;
    endtask

    task automatic idle_inputs();
        load = 1'b0; seed = '0; run = 1'b0; burst_start = 1'b0; burst_len = '0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_val("rst_lfsr", 32'(lfsr_out), 32'(SEED));
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_lockup", 32'(lockup), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        do_reset();

        // Free-run two steps from the reset seed
        run = 1'b1;
        tick();
        check_val("run_step1", 32'(lfsr_out), 32'h5670);
        tick();
        check_val("run_step2", 32'(lfsr_out), 32'hAB38);
        run = 1'b0;
        tick();

        // Burst of 3 from reset
        do_reset();
        busy_seen = 0; done_seen = 0;
        burst_start = 1'b1; burst_len = 8'd3;
        tick();
        burst_start = 1'b0; burst_len = '0;
        repeat (5) tick();
        check_val("burst3_end", 32'(lfsr_out), 32'h559C);
        check_val("burst3_busy_cycles", 32'(busy_seen), 32'd3);
        check_val("burst3_done_pulses", 32'(done_seen), 32'd1);

        // Zero-length burst: done only, no step
        busy_seen = 0; done_seen = 0;
        burst_start = 1'b1; burst_len = 8'd0;
        tick();
        check_val("len0_done", 32'(done), 32'd1);
        burst_start = 1'b0;
        repeat (2) tick();
        check_val("len0_lfsr", 32'(lfsr_out), 32'h559C);
        check_val("len0_busy_cycles", 32'(busy_seen), 32'd0);
        check_val("len0_done_pulses", 32'(done_seen), 32'd1);

        // Load aborts a 5-step burst in its second cycle
        busy_seen = 0; done_seen = 0;
        burst_start = 1'b1; burst_len = 8'd5;
        tick();
        burst_start = 1'b0;
        tick();
        load = 1'b1; seed = 16'h1234;
        tick();
        check_val("abort_lfsr", 32'(lfsr_out), 32'h1234);
        check_val("abort_busy", 32'(busy), 32'd0);
        load = 1'b0;
        repeat (6) tick();
        check_val("abort_done_pulses", 32'(done_seen), 32'd0);
        check_val("abort_hold", 32'(lfsr_out), 32'h1234);

        // All-zero state
        load = 1'b1; seed = '0;
        tick();
        load = 1'b0; run = 1'b1;
        tick();
`ifdef LFSR_GEN_LOCKUP_EN
        check_val("zero_recover", 32'(lfsr_out), 32'(SEED));
        check_val("zero_lockup", 32'(lockup), 32'd1);
        tick();
        check_val("zero_lockup_pulse", 32'(lockup), 32'd0);
`else
        check_val("zero_stuck", 32'(lfsr_out), 32'd0);
        check_val("zero_lockup", 32'(lockup), 32'd0);
        tick();
        check_val("zero_stuck2", 32'(lfsr_out), 32'd0);
        load = 1'b1; seed = 16'hBEEF;
        tick();
`endif
        idle_inputs();

        // Random mixed traffic
        for (int n = 0; n < 400; n++) begin
            run         = ($urandom_range(0, 3) == 0);
            burst_start = ($urandom_range(0, 4) == 0);
            burst_len   = CW'($urandom_range(0, 6));
            load        = ($urandom_range(0, 19) == 0);
            seed        = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            tick();
        end
        idle_inputs();
        tick();

        // Asynchronous reset mid-burst with run high
        burst_start = 1'b1; burst_len = 8'd10; run = 1'b1;
        tick();
        burst_start = 1'b0;
        tick();
        tick();
        check_val("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_val("async_rst_lfsr", 32'(lfsr_out), 32'(SEED));
        check_val("async_rst_busy", 32'(busy), 32'd0);
        check_val("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random generator: the next-generation replacement for the fixed 16-bit, fixed-tap generator used by the lab pattern and test-stimulus paths. Width, tap mask and reset seed are parameters. Stepping is controlled by a free-run enable or by a counted burst with a busy/done handshake. Optional all-zero lock-up recovery is compiled in by macro.

## Interface
- `W`, 16, register width (≥3)
- `TAPS`, 16'h002D, feedback tap mask; bit i set means `lfsr_out[i]` is XORed into the feedback (default is taps 0, 2, 3, 5)
- `RESET_SEED`, 16'hACE1, state after reset and lock-up recovery; must be non-zero
- `CW`, 8, burst counter width
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low reset
- `load` in 1: load `seed` into the register
- `seed` in W: value loaded by `load`
- `run` in 1: free-run step enable
- `burst_start` in 1: request a burst of `burst_len` steps
- `burst_len` in CW: burst step count, sampled with `burst_start`
- `busy` out 1: burst in progress
- `done` out 1: one-cycle pulse at burst completion
- `lfsr_out` out W: register state
- `bit_out` out 1: `lfsr_out[0]`, combinational
- `lockup` out 1: one-cycle pulse on recovery from all-zero

## Operation
- Step (right shift): `fb = ^(lfsr_out & TAPS)`; next state = `{fb, lfsr_out[W-1:1]}`.
- Step enable = `run` OR (FSM in BURST). At most one step per cycle, even when both are true.
- Priority per edge: `load` > step > hold.
  - `load` writes `seed`, including 0.
  - `load` in BURST or DONE aborts to IDLE with no `done` pulse.
- FSM:
  - IDLE: on `burst_start`, sample `burst_len`.
    - `burst_len` = 0: go to DONE. No step is taken.
    - `burst_len` > 0: go to BURST with count = `burst_len`. No step on the accepting edge.
  - BURST: each edge steps and decrements count. When count = 1, step and go to DONE.
  - DONE: `done` = 1 for one cycle, then IDLE.
  - `burst_start` outside IDLE is ignored.
- `busy` = (state == BURST). It is high for exactly `burst_len` cycles.
- Outputs after reset: `lfsr_out` = `RESET_SEED`, state IDLE, `busy` = 0, `done` = 0, `lockup` = 0, count = 0.
- Reset mid-burst: immediate return to reset values; no `done`.

## Timing
- `lfsr_out` updates on the edge where a step or load is taken; there is no extra pipeline stage.
- `burst_start` sampled at edge E0:
  - `busy` is high from E0 through E`burst_len`.
  - Steps occur at edges E1 through E`burst_len`.
  - `done` is high in the cycle after edge E`burst_len`+... specifically, `done` is asserted from edge E`burst_len` to edge E`burst_len`+1.
- `burst_len` = 0: `done` is high from E0 to E1.
- `done`, `busy` and `lockup` are registered outputs.
- `bit_out` is combinational from `lfsr_out`.

## Configuration
- `LFSR_GEN_LOCKUP_EN` defined:
  - A step taken while `lfsr_out` = 0 loads `RESET_SEED` instead of shifting.
  - `lockup` pulses for one cycle.
  - The recovery counts as a burst step.
- `LFSR_GEN_LOCKUP_EN` undefined:
  - The all-zero state shifts to zero, so the register stays stuck at 0.
  - `lockup` is tied to 0.

## Test plan
- Reset, then `run` = 1 for 2 cycles: `lfsr_out` = 16'hACE1, then 16'h5670, then 16'hAB38; `bit_out` follows bit 0.
- From reset, `burst_start` with `burst_len` = 3, `run` = 0:
  - `busy` high for 3 cycles.
  - `lfsr_out` ends at 16'h559C.
  - `done` pulses once, one cycle after the last step.
- `burst_len` = 0: `done` pulses in the next cycle, `busy` never rises, `lfsr_out` unchanged.
- `load` `seed` = 16'h1234 in the second cycle of a 5-step burst: `lfsr_out` = 16'h1234, `busy` drops, no `done`, FSM returns to IDLE.
- `load` `seed` = 0, then `run` = 1:
  - With `LFSR_GEN_LOCKUP_EN`: next state 16'hACE1 and a `lockup` pulse.
  - Without it: `lfsr_out` stays 0 and `lockup` stays 0.
- Assert `reset` low mid-burst with `run` = 1: `lfsr_out` = 16'hACE1 and `busy`/`done` = 0 immediately, with no clock edge required.
